rasterizer_setup_tiled: RTL and testbench
=========================================

Name: rasterizer_setup_tiled

Overview:
Next-generation triangle setup stage for the tiled rasterizer. It takes screen-space triangles over a valid/ready input and clips each bounding box to a per-triangle tile origin. It applies a selectable cull mode and normalises winding so that interior edge values are always positive, with an optional top-left fill-rule bias. Results go out over a valid/ready interface with backpressure to the per-tile rasterizer backend.

Parameters:
DATAWIDTH, 12, signed coordinate width; edge values are 2*DATAWIDTH.
TILE_WIDTH, 32, tile width in pixels.
TILE_HEIGHT, 32, tile height in pixels.
FILL_RULE_EN, 1, 1 applies the top-left bias to edge values.
CNT_WIDTH, 16, width of the statistics counters.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
in_valid  in  1  triangle present
in_ready  out  1  block can accept a triangle
i_v0, i_v1, i_v2  in  3 x DATAWIDTH signed each  vertices [x,y,z]; z is passed through
i_tile_origin  in  2 x DATAWIDTH signed  tile top-left [x,y]
i_cull_mode  in  2  0 none, 1 cull area<=0, 2 cull area>=0, 3 behaves as 1
out_valid  out  1  setup result valid
out_ready  in  1  downstream accepts
bb_tl, bb_br  out  2 x DATAWIDTH signed  clipped bounding box, inclusive
edge_val0..2  out  2*DATAWIDTH signed  edge values at bb_tl
edge_delta0..2  out  2 x DATAWIDTH signed each  per-pixel [dx,dy] increments
area  out  2*DATAWIDTH signed  absolute area, always >0 when valid
winding_flipped  out  1  input area was negative
z_out  out  3 x DATAWIDTH  z of v0, v1, v2
emit_count, cull_count  out  CNT_WIDTH  saturating statistics counters

Behaviour:
- Reset (rstn=0 at a clk edge): state goes to IDLE.
  - in_ready=0 during the reset cycle; it returns to 1 in the first IDLE cycle after reset.
  - out_valid=0; all data outputs and both counters go to 0.
  - Reset mid-operation discards the triangle in flight without emitting it.
- Edge function: E(a,b,p) = (px-ax)*(by-ay) - (py-ay)*(bx-ax), computed at 2*DATAWIDTH.
  - Delta for edge (a,b) = [by-ay, -(bx-ax)], computed at DATAWIDTH.
- Area is E(v0,v1,v2).
  - Edge 0 = (v0,v1), edge 1 = (v1,v2), edge 2 = (v2,v0).
  - All edges are evaluated at p = bb_tl.
- Bounding box:
  - min/max of the vertices, clipped to [origin, origin + TILE_WIDTH-1] in x and [origin, origin + TILE_HEIGHT-1] in y.
  - The box is empty if min>max on either axis.
- A single shared edge-function unit is used sequentially.
- FSM states: IDLE, AREA, CULL_EDGE0, EDGE1, EDGE2, FINALIZE, OUT.
  - IDLE: in_ready=1. On in_valid, latch vertices, tile origin and cull mode, then go to AREA.
  - AREA: register area and the clipped box.
  - CULL_EDGE0: cull when any of the following holds:
    - area==0;
    - the box is empty;
    - mode 1 or 3 and area<0;
    - mode 2 and area>0.
    - On cull: increment cull_count and go to IDLE. Otherwise register edge 0 and go to EDGE1.
  - EDGE1, EDGE2: register edges 1 and 2.
  - FINALIZE:
    - If area<0, negate all edge values, all deltas and area, and set winding_flipped.
    - If FILL_RULE_EN, subtract 1 from every edge that is not top-left. Top-left means delta_x>0, or delta_x==0 and delta_y>0, evaluated after normalisation.
    - Load the outputs.
  - OUT: out_valid=1. On out_ready, increment emit_count and go to IDLE.
- Latency, with acceptance at edge T:
  - out_valid first samples high at edge T+6.
  - A culled triangle has in_ready high again at T+3.
  - Throughput is at most 1 triangle per 7 cycles.
- Backpressure: while out_valid=1 and out_ready=0, every output is held stable and in_ready=0.
- in_ready is 0 in every state except IDLE; inputs presented then are ignored.
- Counters saturate at all-ones and do not wrap.
- Overflow: with |coords| < 2^(DATAWIDTH-2), no overflow occurs. Outside that range the result is undefined but must not hang the FSM.

Test Plan:
1. Basic CCW triangle: v0=(10,10), v1=(10,20), v2=(20,10), origin (0,0), mode 1.
   - bb (10,10)-(20,20), area 100.
   - Deltas (10,0), (-10,-10), (0,10).
   - Edges (0,99,0) with fill rule; raw edges would be (0,100,0).
   - winding_flipped=0; out_valid at T+6; emit_count=1.
2. CW winding, mode 0: v1 and v2 swapped.
   - area 100, winding_flipped=1.
   - Deltas (0,10), (-10,-10), (10,0); edges (0,99,0).
3. Culling:
   - Same CW triangle with mode 1 -> no out_valid, cull_count=1, in_ready high at T+3.
   - Degenerate collinear triangle with mode 0 -> culled.
4. Tile clip:
   - Case 1 triangle with origin (16,16) -> bb (16,16)-(20,20), edges (60,-21,60).
   - Origin (32,0) -> empty box, culled.
5. Backpressure: hold out_ready=0 for 5 cycles in OUT.
   - Outputs stable; in_ready=0.
   - The next in_valid is ignored until the handshake completes.
   - emit_count increments exactly once.
6. Reset during EDGE1: rstn low for 1 cycle.
   - out_valid=0, counters=0; in_ready=1 on the cycle after rstn returns high.
   - The triangle is never emitted.

Source files
------------

// File: rtl/rasterizer_setup_tiled.sv
// Triangle setup for the tiled rasterizer. It clips the bounding box to the tile, culls,
// normalises winding and applies the top-left bias. Vector ports pack x (or z0) in the low field.
module rasterizer_setup_tiled #(
    parameter int DATAWIDTH    = 12,
    parameter int TILE_WIDTH   = 32,
    parameter int TILE_HEIGHT  = 32,
    parameter int FILL_RULE_EN = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3*DATAWIDTH-1:0]   i_v0,
    input  logic [3*DATAWIDTH-1:0]   i_v1,
    input  logic [3*DATAWIDTH-1:0]   i_v2,
    input  logic [2*DATAWIDTH-1:0]   i_tile_origin,
    input  logic [1:0]               i_cull_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*DATAWIDTH-1:0]   bb_tl,
    output logic [2*DATAWIDTH-1:0]   bb_br,
    output logic [2*DATAWIDTH-1:0]   edge_val0,
    output logic [2*DATAWIDTH-1:0]   edge_val1,
    output logic [2*DATAWIDTH-1:0]   edge_val2,
    output logic [2*DATAWIDTH-1:0]   edge_delta0,
    output logic [2*DATAWIDTH-1:0]   edge_delta1,
    output logic [2*DATAWIDTH-1:0]   edge_delta2,
    output logic [2*DATAWIDTH-1:0]   area,
    output logic                     winding_flipped,
    output logic [3*DATAWIDTH-1:0]   z_out,
    output logic [CNT_WIDTH-1:0]     emit_count,
    output logic [CNT_WIDTH-1:0]     cull_count
);
    // state      | meaning
    // IDLE       | ready for a triangle
    // AREA       | signed area and clipped box
    // CULL_EDGE0 | cull decision, else edge 0
    // EDGE1      | edge 1
    // EDGE2      | edge 2
    // FINALIZE   | winding normalisation, fill bias, output load
    // OUT        | result presented until accepted
    localparam int DW = DATAWIDTH;
    localparam int EW = 2 * DATAWIDTH;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_AREA       = 3'd1;
    localparam logic [2:0] S_CULL_EDGE0 = 3'd2;
    localparam logic [2:0] S_EDGE1      = 3'd3;
    localparam logic [2:0] S_EDGE2      = 3'd4;
    localparam logic [2:0] S_FINALIZE   = 3'd5;
    localparam logic [2:0] S_OUT        = 3'd6;

    logic [2:0]           state;
    logic signed [DW-1:0] vx [3];
    logic signed [DW-1:0] vy [3];
    logic [3*DW-1:0]      z_q;
    logic signed [DW-1:0] org_x, org_y;
    logic [1:0]           mode_q;
    logic signed [DW-1:0] bx_min, by_min, bx_max, by_max;
    logic signed [EW-1:0] area_q;
    logic signed [EW-1:0] e_q [3];

    function automatic logic signed [DW-1:0] smin(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [EW-1:0] sx(input logic signed [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    function automatic logic is_top_left(input logic signed [DW-1:0] dx,
                                         input logic signed [DW-1:0] dy);
        return (!dx[DW-1] && dx != '0) || (dx == '0 && !dy[DW-1] && dy != '0);
    endfunction

    assign in_ready = rstn && (state == S_IDLE);

    logic signed [DW-1:0] hi_x, hi_y, clip_x0, clip_x1, clip_y0, clip_y1;

    always_comb begin
        hi_x    = org_x + DW'(TILE_WIDTH - 1);
        hi_y    = org_y + DW'(TILE_HEIGHT - 1);
        clip_x0 = smax(smin(smin(vx[0], vx[1]), vx[2]), org_x);
        clip_x1 = smin(smax(smax(vx[0], vx[1]), vx[2]), hi_x);
        clip_y0 = smax(smin(smin(vy[0], vy[1]), vy[2]), org_y);
        clip_y1 = smin(smax(smax(vy[0], vy[1]), vy[2]), hi_y);
    end

    // Single shared edge-function unit; operands are steered by the current state.
    logic signed [DW-1:0] ea_x, ea_y, eb_x, eb_y, ep_x, ep_y;
    logic signed [EW-1:0] edge_res;

    always_comb begin
        ea_x = vx[0]; ea_y = vy[0];
        eb_x = vx[1]; eb_y = vy[1];
        ep_x = vx[2]; ep_y = vy[2];
        case (state)
            S_CULL_EDGE0: begin
                ep_x = bx_min; ep_y = by_min;
            end
            S_EDGE1: begin
                ea_x = vx[1]; ea_y = vy[1];
                eb_x = vx[2]; eb_y = vy[2];
                ep_x = bx_min; ep_y = by_min;
            end
            S_EDGE2: begin
                ea_x = vx[2]; ea_y = vy[2];
                eb_x = vx[0]; eb_y = vy[0];
                ep_x = bx_min; ep_y = by_min;
            end
            default: ;
        endcase
        edge_res = (sx(ep_x) - sx(ea_x)) * (sx(eb_y) - sx(ea_y))
                 - (sx(ep_y) - sx(ea_y)) * (sx(eb_x) - sx(ea_x));
    end

    logic box_empty, area_neg, area_pos, cull;

    always_comb begin
        box_empty = (bx_min > bx_max) || (by_min > by_max);
        area_neg  = area_q[EW-1];
        area_pos  = !area_neg && (area_q != '0);
        cull      = (area_q == '0) || box_empty || (mode_q[0] && area_neg)
                  || ((mode_q == 2'd2) && area_pos);
    end

    logic signed [DW-1:0] dx_raw [3];
    logic signed [DW-1:0] dy_raw [3];
    logic signed [DW-1:0] dx_n [3];
    logic signed [DW-1:0] dy_n [3];
    logic signed [EW-1:0] e_n [3];
    logic signed [EW-1:0] area_n;
    logic                 flip;

    // Top-left test runs on the normalised deltas so the bias follows the positive-interior winding.
    always_comb begin
        flip   = area_q[EW-1];
        area_n = flip ? -area_q : area_q;
        for (int i = 0; i < 3; i++) begin
            dx_raw[i] = vy[(i + 1) % 3] - vy[i];
            dy_raw[i] = vx[i] - vx[(i + 1) % 3];
            dx_n[i]   = flip ? -dx_raw[i] : dx_raw[i];
            dy_n[i]   = flip ? -dy_raw[i] : dy_raw[i];
            e_n[i]    = flip ? -e_q[i] : e_q[i];
            if (FILL_RULE_EN != 0 && !is_top_left(dx_n[i], dy_n[i]))
                e_n[i] = e_n[i] - EW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            vx[0]  <= $signed(i_v0[DW-1:0]);
            vy[0]  <= $signed(i_v0[2*DW-1:DW]);
            vx[1]  <= $signed(i_v1[DW-1:0]);
            vy[1]  <= $signed(i_v1[2*DW-1:DW]);
            vx[2]  <= $signed(i_v2[DW-1:0]);
            vy[2]  <= $signed(i_v2[2*DW-1:DW]);
            z_q    <= {i_v2[3*DW-1:2*DW], i_v1[3*DW-1:2*DW], i_v0[3*DW-1:2*DW]};
            org_x  <= $signed(i_tile_origin[DW-1:0]);
            org_y  <= $signed(i_tile_origin[2*DW-1:DW]);
            mode_q <= i_cull_mode;
        end
        case (state)
            S_AREA: begin
                area_q <= edge_res;
                bx_min <= clip_x0;
                bx_max <= clip_x1;
                by_min <= clip_y0;
                by_max <= clip_y1;
            end
            S_CULL_EDGE0: e_q[0] <= edge_res;
            S_EDGE1:      e_q[1] <= edge_res;
            S_EDGE2:      e_q[2] <= edge_res;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= S_IDLE;
            out_valid       <= 1'b0;
            bb_tl           <= '0;
            bb_br           <= '0;
            edge_val0       <= '0;
            edge_val1       <= '0;
            edge_val2       <= '0;
            edge_delta0     <= '0;
            edge_delta1     <= '0;
            edge_delta2     <= '0;
            area            <= '0;
            winding_flipped <= 1'b0;
            z_out           <= '0;
            emit_count      <= '0;
            cull_count      <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) state <= S_AREA;
                S_AREA: state <= S_CULL_EDGE0;
                S_CULL_EDGE0: begin
                    if (cull) begin
                        if (cull_count != '1) cull_count <= cull_count + CNT_WIDTH'(1);
                        state <= S_IDLE;
                    end else begin
                        state <= S_EDGE1;
                    end
                end
                S_EDGE1: state <= S_EDGE2;
                S_EDGE2: state <= S_FINALIZE;
                S_FINALIZE: begin
                    bb_tl           <= {by_min, bx_min};
                    bb_br           <= {by_max, bx_max};
                    edge_val0       <= e_n[0];
                    edge_val1       <= e_n[1];
                    edge_val2       <= e_n[2];
                    edge_delta0     <= {dy_n[0], dx_n[0]};
                    edge_delta1     <= {dy_n[1], dx_n[1]};
                    edge_delta2     <= {dy_n[2], dx_n[2]};
                    area            <= area_n;
                    winding_flipped <= flip;
                    z_out           <= z_q;
                    out_valid       <= 1'b1;
                    state           <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (emit_count != '1) emit_count <= emit_count + CNT_WIDTH'(1);
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rasterizer_setup_tiled.sv
// Scoreboard bench for rasterizer_setup_tiled: directed cases, then randomized triangles
// against an integer reference model of the setup arithmetic.
module tb_rasterizer_setup_tiled;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [3*DW-1:0] i_v0 = '0, i_v1 = '0, i_v2 = '0;
    logic [2*DW-1:0] i_tile_origin = '0;
    logic [1:0]      i_cull_mode = '0;
    logic            in_ready, out_valid, winding_flipped;
    logic [2*DW-1:0] bb_tl, bb_br, edge_val0, edge_val1, edge_val2;
    logic [2*DW-1:0] edge_delta0, edge_delta1, edge_delta2, area;
    logic [3*DW-1:0] z_out;
    logic [15:0]     emit_count, cull_count;

    rasterizer_setup_tiled dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .i_v0(i_v0), .i_v1(i_v1), .i_v2(i_v2), .i_tile_origin(i_tile_origin),
        .i_cull_mode(i_cull_mode), .out_valid(out_valid), .out_ready(out_ready),
        .bb_tl(bb_tl), .bb_br(bb_br), .edge_val0(edge_val0), .edge_val1(edge_val1),
        .edge_val2(edge_val2), .edge_delta0(edge_delta0), .edge_delta1(edge_delta1),
        .edge_delta2(edge_delta2), .area(area), .winding_flipped(winding_flipped),
        .z_out(z_out), .emit_count(emit_count), .cull_count(cull_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tlx, tly, brx, bry;
        int e0, e1, e2;
        int dx0, dy0, dx1, dy1, dx2, dy2;
        int area, flip, z0, z1, z2;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_emit = 0;
    int   exp_cull = 0;
    bit   rand_ready = 1'b0;
    bit   ready_force = 1'b1;
    bit   holding = 1'b0;
    logic [252:0] snap;
    wire  [252:0] out_bus = {bb_tl, bb_br, edge_val0, edge_val1, edge_val2, edge_delta0,
                             edge_delta1, edge_delta2, area, winding_flipped, z_out};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    function automatic int efn(input int ax, input int ay, input int bx, input int by,
                               input int px, input int py);
        return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
    endfunction

    function automatic int bias(input int dx, input int dy);
        return (dx > 0 || (dx == 0 && dy > 0)) ? 0 : 1;
    endfunction

    // Returns 1 when the triangle must be culled; otherwise fills the expected result.
    function automatic bit model(input int x0, input int y0, input int z0,
                                 input int x1, input int y1, input int z1,
                                 input int x2, input int y2, input int z2,
                                 input int ox, input int oy, input int mode, output res_t r);
        int a, s;
        r = '{default: 0};
        r.tlx = imax(imin(imin(x0, x1), x2), ox);
        r.brx = imin(imax(imax(x0, x1), x2), ox + 31);
        r.tly = imax(imin(imin(y0, y1), y2), oy);
        r.bry = imin(imax(imax(y0, y1), y2), oy + 31);
        a = efn(x0, y0, x1, y1, x2, y2);
        if (a == 0 || r.tlx > r.brx || r.tly > r.bry || ((mode == 1 || mode == 3) && a < 0)
            || (mode == 2 && a > 0))
            return 1'b1;
        s = (a < 0) ? -1 : 1;
        r.flip = (a < 0) ? 1 : 0;
        r.area = a * s;
        r.dx0 = s * (y1 - y0); r.dy0 = -s * (x1 - x0);
        r.dx1 = s * (y2 - y1); r.dy1 = -s * (x2 - x1);
        r.dx2 = s * (y0 - y2); r.dy2 = -s * (x0 - x2);
        r.e0 = s * efn(x0, y0, x1, y1, r.tlx, r.tly) - bias(r.dx0, r.dy0);
        r.e1 = s * efn(x1, y1, x2, y2, r.tlx, r.tly) - bias(r.dx1, r.dy1);
        r.e2 = s * efn(x2, y2, x0, y0, r.tlx, r.tly) - bias(r.dx2, r.dy2);
        r.z0 = z0; r.z1 = z1; r.z2 = z2;
        return 1'b0;
    endfunction

    task automatic send(input int x0, input int y0, input int z0, input int x1, input int y1,
                        input int z1, input int x2, input int y2, input int z2,
                        input int ox, input int oy, input int mode, input bit track);
        res_t r;
        bit   c;
        int   waited = 0;
        @(negedge clk);
        i_v0 = {DW'(z0), DW'(y0), DW'(x0)};
        i_v1 = {DW'(z1), DW'(y1), DW'(x1)};
        i_v2 = {DW'(z2), DW'(y2), DW'(x2)};
        i_tile_origin = {DW'(oy), DW'(ox)};
        i_cull_mode = 2'(mode);
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 300) begin
                check("accept_timeout", waited, 0);
                finish_now();
            end
        end
        @(posedge clk);
        c = model(x0, y0, z0, x1, y1, z1, x2, y2, z2, ox, oy, mode, r);
        if (track) begin
            if (c) exp_cull++;
            else exp_q.push_back(r);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(exp_q.size() == 0 && in_ready && !out_valid) && waited < 500);
        if (waited >= 500) begin
            check("drain_timeout", waited, 0);
            finish_now();
        end
    endtask

    task automatic compare_pop();
        res_t r;
        if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
            return;
        end
        r = exp_q.pop_front();
        exp_emit++;
        check("bb_tl_x", $signed(bb_tl[DW-1:0]), r.tlx);
        check("bb_tl_y", $signed(bb_tl[2*DW-1:DW]), r.tly);
        check("bb_br_x", $signed(bb_br[DW-1:0]), r.brx);
        check("bb_br_y", $signed(bb_br[2*DW-1:DW]), r.bry);
        check("edge0", $signed(edge_val0), r.e0);
        check("edge1", $signed(edge_val1), r.e1);
        check("edge2", $signed(edge_val2), r.e2);
        check("delta0_x", $signed(edge_delta0[DW-1:0]), r.dx0);
        check("delta0_y", $signed(edge_delta0[2*DW-1:DW]), r.dy0);
        check("delta1_x", $signed(edge_delta1[DW-1:0]), r.dx1);
        check("delta1_y", $signed(edge_delta1[2*DW-1:DW]), r.dy1);
        check("delta2_x", $signed(edge_delta2[DW-1:0]), r.dx2);
        check("delta2_y", $signed(edge_delta2[2*DW-1:DW]), r.dy2);
        check("area", $signed(area), r.area);
        check("winding_flipped", int'(winding_flipped), r.flip);
        check("z0", int'(z_out[DW-1:0]), r.z0);
        check("z1", int'(z_out[2*DW-1:DW]), r.z1);
        check("z2", int'(z_out[3*DW-1:2*DW]), r.z2);
    endtask

    // Monitor: pops on each handshake and checks that a stalled result stays put.
    always @(negedge clk) begin
        if (!rstn) begin
            holding = 1'b0;
        end else if (out_valid) begin
            if (holding) begin
                n_checks++;
                if (out_bus !== snap) begin
                    n_fail++;
                    $display("FAIL hold_stable: got %h, expected %h", out_bus, snap);
                end
            end
            check("in_ready_while_out", int'(in_ready), 0);
            if (out_ready) begin
                holding = 1'b0;
                compare_pop();
            end else begin
                holding = 1'b1;
                snap = out_bus;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_force;
        end
    end

    initial begin
        #1000000;
        check("global_timeout", 1, 0);
        finish_now();
    end

    initial begin
        int k;
        int ox, oy;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_emit", int'(emit_count), 0);
        check("rst_cull", int'(cull_count), 0);
        check("rst_area", $signed(area), 0);
        check("rst_edge0", $signed(edge_val0), 0);
        check("rst_bb_tl", int'(bb_tl), 0);
        rstn = 1'b1;
        #1 check("in_ready_after_reset", int'(in_ready), 1);

        // basic CCW triangle and its latency
        send(10, 10, 5, 10, 20, 6, 20, 10, 7, 0, 0, 1, 1'b1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        check("t1_latency", k, 6);
        check("t1_area", $signed(area), 100);
        check("t1_edge0", $signed(edge_val0), 0);
        check("t1_edge1", $signed(edge_val1), 99);
        check("t1_edge2", $signed(edge_val2), 0);
        drain();
        check("t1_emit_count", int'(emit_count), exp_emit);

        // CW winding, no culling
        send(10, 10, 5, 20, 10, 7, 10, 20, 6, 0, 0, 0, 1'b1);
        drain();

        // CW with mode 1 is culled and frees the input quickly
        send(10, 10, 5, 20, 10, 7, 10, 20, 6, 0, 0, 1, 1'b1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 20);
        check("t3_cull_ready", k, 3);
        drain();
        check("t3_cull_count", int'(cull_count), exp_cull);
        send(0, 0, 1, 5, 5, 2, 10, 10, 3, 0, 0, 0, 1'b1);
        drain();

        // tile clipping, then a box that misses the tile
        send(10, 10, 5, 10, 20, 6, 20, 10, 7, 16, 16, 1, 1'b1);
        send(10, 10, 5, 10, 20, 6, 20, 10, 7, 32, 0, 1, 1'b1);
        drain();
        check("t4_cull_count", int'(cull_count), exp_cull);
        check("t4_emit_count", int'(emit_count), exp_emit);

        // backpressure; the second triangle waits until the handshake completes
        @(negedge clk);
        ready_force = 1'b0;
        send(10, 10, 5, 10, 20, 6, 20, 10, 7, 0, 0, 1, 1'b1);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_out_valid_seen", int'(out_valid), 1);
        fork
            begin
                repeat (5) @(negedge clk);
                ready_force = 1'b1;
            end
            send(10, 10, 9, 20, 10, 8, 10, 20, 7, 0, 0, 0, 1'b1);
        join
        drain();
        check("t5_emit_count", int'(emit_count), exp_emit);

        // reset while the triangle is in EDGE1
        send(10, 10, 5, 10, 20, 6, 20, 10, 7, 0, 0, 1, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1 check("t6_in_ready_in_reset", int'(in_ready), 0);
        @(negedge clk);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_emit", int'(emit_count), 0);
        check("t6_cull", int'(cull_count), 0);
        rstn = 1'b1;
        exp_emit = 0;
        exp_cull = 0;
        #1 check("t6_in_ready_after", int'(in_ready), 1);
        repeat (10) @(negedge clk);
        check("t6_no_emit", int'(emit_count), 0);

        // randomized triangles with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ox = int'($urandom_range(0, 128)) - 64;
            oy = int'($urandom_range(0, 128)) - 64;
            send(ox + int'($urandom_range(0, 80)) - 20, oy + int'($urandom_range(0, 80)) - 20,
                 int'($urandom_range(0, 4095)),
                 ox + int'($urandom_range(0, 80)) - 20, oy + int'($urandom_range(0, 80)) - 20,
                 int'($urandom_range(0, 4095)),
                 ox + int'($urandom_range(0, 80)) - 20, oy + int'($urandom_range(0, 80)) - 20,
                 int'($urandom_range(0, 4095)),
                 ox, oy, int'($urandom_range(0, 3)), 1'b1);
        end
        drain();
        check("final_emit_count", int'(emit_count), exp_emit);
        check("final_cull_count", int'(cull_count), exp_cull);
        finish_now();
    end

endmodule
